id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  Decode->execute pipeline register that consumes register-file read data (rdata1/rdata2) plus
//  decoded fields and holds them for the EX stage.
//  Provides valid/ready flow control, flush, load-use hazard detection with bubble insertion,
//  and an optional writeback bypass into the captured operands.
// PARAMETERS
//  XLEN          32  datapath width (pc, operands, immediate)
//  CTRL_W         8  width of opaque decoded-control bundle passed to EX
//  LOAD_BUBBLES   1  stall cycles inserted per load-use hazard; legal range 1..4
// PORTS
//  clk           in   1       clock, all state updates on posedge
//  rst           in   1       synchronous, active-high reset
//  flush         in   1       kill held instruction (branch/jump redirect)
//  in_valid      in   1       decode presents an instruction
//  in_ready      out  1       stage accepts the instruction this cycle
//  in_pc         in   XLEN    instruction PC
//  in_rs1        in   5       source register 1 index
//  in_rs2        in   5       source register 2 index
//  in_rd         in   5       destination register index
//  in_rdata1     in   XLEN    register-file contents of rs1
//  in_rdata2     in   XLEN    register-file contents of rs2
//  in_imm        in   XLEN    sign-extended immediate
//  in_ctrl       in   CTRL_W  decoded control bundle
//  in_is_load    in   1       instruction is a load
//  wb_we         in   1       writeback write enable (same as register-file write enable)
//  wb_rd         in   5       writeback destination
//  wb_data       in   XLEN    writeback data
//  out_valid     out  1       EX-side instruction valid
//  out_ready     in   1       EX accepts the held instruction
//  out_pc, out_rs1, out_rs2, out_rd, out_rdata1, out_rdata2, out_imm, out_ctrl, out_is_load
//                out  as in   registered copies of the in_* fields
//  out_stall_cnt out  16      saturating count of load-use bubble cycles since reset
// BEHAVIOUR
//  - Reset: every out_* register = 0, out_stall_cnt = 0, state = RUN, bubble counter = 0.
//  - States: RUN, BUBBLE.
//  - hazard = RUN & in_valid & out_valid & out_is_load & out_rd!=0 &
//    (out_rd==in_rs1 | out_rd==in_rs2).
//  - in_ready = flush | (state==RUN & !hazard & (!out_valid | out_ready)); purely combinational.
//  - Priority at each posedge: rst > flush > hazard > accept > hold.
//  - Flush:
//    - out_valid <= 0, state <= RUN, bubble counter <= 0.
//    - Input presented in the same cycle is discarded even though in_ready = 1.
//  - Hazard with out_ready = 1:
//    - Held load leaves; out_valid <= 0 (bubble).
//    - out_stall_cnt increments.
//    - If LOAD_BUBBLES > 1, state <= BUBBLE with counter = LOAD_BUBBLES-2; otherwise stay RUN.
//  - Hazard with out_ready = 0: hold all outputs unchanged; counter unchanged.
//  - BUBBLE:
//    - in_ready = 0, out_valid <= 0, out_stall_cnt increments each cycle.
//    - Counter==0 -> RUN, else decrement.
//    - Total stall = LOAD_BUBBLES cycles per hazard.
//  - Accept (in_valid & in_ready, no flush): all out_* <= in_*, out_valid <= 1, zero latency.
//  - EX consumes without new input (out_ready & out_valid & !(in_valid & in_ready)): out_valid <= 0.
//  - rs index 0 never matches for hazard; rd==0 never raises a hazard.
//  - out_stall_cnt saturates at 16'hFFFF; flush does not clear it.
// CONFIGURATION
//  FORWARD_WB_EN defined:
//    - On accept, if wb_we & wb_rd!=0 & wb_rd==in_rs1, capture out_rdata1 <= wb_data; same for rs2.
//    - While holding (valid, not accepted), a matching writeback also updates the held operand.
//  FORWARD_WB_EN undefined:
//    - Operands are captured solely from in_rdata1/in_rdata2.
//    - wb_* ports are present but ignored.
// TESTING
//  1 Reset: rst=1 two cycles -> out_valid=0, in_ready=1, out_stall_cnt=0, all out_* = 0.
//  2 Stream add x5,x1,x2 then sub x6,x3,x4 with out_ready=1
//    -> each appears the cycle after accept, no stall.
//  3 Load-use, LOAD_BUBBLES=2: lw x7 then add x8,x7,x1
//    -> in_ready low 2 cycles, out_valid=0 for 2 cycles, out_stall_cnt=2.
//  4 out_ready=0 for 3 cycles with valid held
//    -> outputs stable, in_ready=0; on release, the next instruction is accepted the same cycle.
//  5 flush during BUBBLE
//    -> next cycle state RUN, out_valid=0, in_ready=1; stalled instruction not executed twice.
//  6 FORWARD_WB_EN: in_rs1=9, in_rdata1=0x11, wb_we=1, wb_rd=9, wb_data=0xABCD
//    -> out_rdata1=0xABCD; without the macro -> 0x11.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode->execute pipeline register.
// Holds register-file operands and decoded fields for EX, with valid/ready
// flow control, flush, load-use bubble insertion and a saturating stall
// counter. Optional macro FORWARD_WB_EN bypasses same-cycle writeback data
// into the captured or held operands.
module id_ex_stage #(
  parameter int XLEN         = 32,
  parameter int CTRL_W       = 8,
  parameter int LOAD_BUBBLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [4:0]        in_rd,
  input  logic [XLEN-1:0]   in_rdata1,
  input  logic [XLEN-1:0]   in_rdata2,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              in_is_load,
  input  logic              wb_we,
  input  logic [4:0]        wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [4:0]        out_rd,
  output logic [XLEN-1:0]   out_rdata1,
  output logic [XLEN-1:0]   out_rdata2,
  output logic [XLEN-1:0]   out_imm,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              out_is_load,
  output logic [15:0]       out_stall_cnt
);

  // Bubbles after the first one are counted down from this value in BUBBLE.
  localparam logic [1:0] BUB_INIT = 2'((LOAD_BUBBLES > 1) ? (LOAD_BUBBLES - 2) : 0);

  typedef enum logic {RUN = 1'b0, BUBBLE = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [1:0]  bub_q, bub_d;
  logic        hazard, accept, stall_tick;

  logic              vld_p1;
  logic [XLEN-1:0]   pc_p1, rdata1_p1, rdata2_p1, imm_p1;
  logic [4:0]        rs1_p1, rs2_p1, rd_p1;
  logic [CTRL_W-1:0] ctrl_p1;
  logic              is_load_p1;
  logic [15:0]       stall_cnt_p1;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Writeback bypass: x0 is never forwarded since it is hardwired to zero.
  function automatic logic [XLEN-1:0] wb_bypass(input logic we, input logic [4:0] wrd,
                                                input logic [XLEN-1:0] wdata,
                                                input logic [4:0] rs,
                                                input logic [XLEN-1:0] dflt);
    return (we && (wrd != 5'd0) && (wrd == rs)) ? wdata : dflt;
  endfunction

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      bub_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      bub_q   <= bub_d;
    end
  end

  // FSM next state: flush wins, BUBBLE counts down, a consumed hazard may enter BUBBLE.
  always_comb begin
    state_d = state_q;
    bub_d   = bub_q;
    if (flush) begin
      state_d = RUN;
      bub_d   = 2'd0;
    end else if (state_q == BUBBLE) begin
      if (bub_q == 2'd0) state_d = RUN;
      else               bub_d   = bub_q - 2'd1;
    end else if (hazard && out_ready && (LOAD_BUBBLES > 1)) begin
      state_d = BUBBLE;
      bub_d   = BUB_INIT;
    end
  end

  // FSM outputs: hazard detection, handshake and stall-tick strobes.
  always_comb begin
    hazard = (state_q == RUN) && in_valid && vld_p1 && is_load_p1 && (rd_p1 != 5'd0) &&
             ((rd_p1 == in_rs1) || (rd_p1 == in_rs2));
    in_ready   = flush || ((state_q == RUN) && !hazard && (!vld_p1 || out_ready));
    accept     = in_valid && in_ready && !flush;
    stall_tick = !flush && ((state_q == BUBBLE) || (hazard && out_ready));
  end

  // Valid bit: kill on flush/bubble, set on accept, clear when EX drains it.
  always_ff @(posedge clk) begin
    if (rst)                        vld_p1 <= 1'b0;
    else if (flush)                 vld_p1 <= 1'b0;
    else if (state_q == BUBBLE)     vld_p1 <= 1'b0;
    else if (hazard && out_ready)   vld_p1 <= 1'b0;
    else if (accept)                vld_p1 <= 1'b1;
    else if (out_ready)             vld_p1 <= 1'b0;
  end

  // Payload: capture on accept; held operands may pick up writeback data.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_p1      <= '0;
      rs1_p1     <= '0;
      rs2_p1     <= '0;
      rd_p1      <= '0;
      rdata1_p1  <= '0;
      rdata2_p1  <= '0;
      imm_p1     <= '0;
      ctrl_p1    <= '0;
      is_load_p1 <= 1'b0;
    end else if (accept) begin
      pc_p1      <= in_pc;
      rs1_p1     <= in_rs1;
      rs2_p1     <= in_rs2;
      rd_p1      <= in_rd;
      imm_p1     <= in_imm;
      ctrl_p1    <= in_ctrl;
      is_load_p1 <= in_is_load;
`ifdef FORWARD_WB_EN
      rdata1_p1  <= wb_bypass(wb_we, wb_rd, wb_data, in_rs1, in_rdata1);
      rdata2_p1  <= wb_bypass(wb_we, wb_rd, wb_data, in_rs2, in_rdata2);
`else
      rdata1_p1  <= in_rdata1;
      rdata2_p1  <= in_rdata2;
`endif
    end
`ifdef FORWARD_WB_EN
    else if (vld_p1) begin
      rdata1_p1  <= wb_bypass(wb_we, wb_rd, wb_data, rs1_p1, rdata1_p1);
      rdata2_p1  <= wb_bypass(wb_we, wb_rd, wb_data, rs2_p1, rdata2_p1);
    end
`endif
  end

  // Saturating load-use stall counter; survives flush.
  always_ff @(posedge clk) begin
    if (rst)             stall_cnt_p1 <= 16'd0;
    else if (stall_tick) stall_cnt_p1 <= sat_inc16(stall_cnt_p1);
  end

`ifndef FORWARD_WB_EN
  logic unused_wb;
  assign unused_wb = ^{wb_we, wb_rd, wb_data, 1'b0 & wb_bypass(1'b0, 5'd0, '0, 5'd0, '0)};
`endif

  assign out_valid     = vld_p1;
  assign out_pc        = pc_p1;
  assign out_rs1       = rs1_p1;
  assign out_rs2       = rs2_p1;
  assign out_rd        = rd_p1;
  assign out_rdata1    = rdata1_p1;
  assign out_rdata2    = rdata2_p1;
  assign out_imm       = imm_p1;
  assign out_ctrl      = ctrl_p1;
  assign out_is_load   = is_load_p1;
  assign out_stall_cnt = stall_cnt_p1;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage with LOAD_BUBBLES=2: reset, streaming,
// load-use bubbles, backpressure, flush, x0 handling and writeback bypass.
module tb_id_ex_stage;

`ifdef FORWARD_WB_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, in_is_load, wb_we;
  logic [31:0] in_pc, in_rdata1, in_rdata2, in_imm, wb_data;
  logic [4:0]  in_rs1, in_rs2, in_rd, wb_rd;
  logic [7:0]  in_ctrl;
  logic        out_valid, out_ready, out_is_load;
  logic [31:0] out_pc, out_rdata1, out_rdata2, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [7:0]  out_ctrl;
  logic [15:0] out_stall_cnt;

  int n_chk = 0;
  int n_fail = 0;

  id_ex_stage #(.XLEN(32), .CTRL_W(8), .LOAD_BUBBLES(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_rdata1(in_rdata1), .in_rdata2(in_rdata2), .in_imm(in_imm), .in_ctrl(in_ctrl),
    .in_is_load(in_is_load), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_rd(out_rd), .out_rdata1(out_rdata1), .out_rdata2(out_rdata2),
    .out_imm(out_imm), .out_ctrl(out_ctrl), .out_is_load(out_is_load),
    .out_stall_cnt(out_stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fl, vl, rdy;
    logic [4:0]  rs1, rs2, rd;
    logic        ld;
    logic [31:0] d1;
    logic        e_irdy, e_ovld;
    logic [4:0]  e_rd;
    logic        e_ld;
    logic [31:0] e_d1;
    logic [15:0] e_stall;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(input logic fl, vl, rdy, input logic [4:0] rs1, rs2, rd,
                              input logic ld, input logic [31:0] d1,
                              input logic eir, eov, input logic [4:0] erd,
                              input logic eld, input logic [31:0] ed1, input logic [15:0] est);
    vec_t v;
    v.fl = fl; v.vl = vl; v.rdy = rdy; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.ld = ld;
    v.d1 = d1; v.e_irdy = eir; v.e_ovld = eov; v.e_rd = erd; v.e_ld = eld;
    v.e_d1 = ed1; v.e_stall = est;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Side fields are derived from rdata1 so one value pins the whole payload.
  task automatic drive(input logic fl, vl, rdy, input logic [4:0] rs1, rs2, rd,
                       input logic ld, input logic [31:0] d1);
    flush = fl; in_valid = vl; out_ready = rdy;
    in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_is_load = ld;
    in_rdata1 = d1; in_rdata2 = d1 ^ 32'hFFFF_0000;
    in_pc = d1 + 32'd4; in_imm = ~d1; in_ctrl = d1[7:0] ^ 8'h5A;
  endtask

  initial begin
    logic [31:0] d;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0);
    wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;

    vecs[0]  = mk(0,1,1,  1, 2, 5,0,32'h1001, 1,1, 5,0,32'h1001,0);
    vecs[1]  = mk(0,1,1,  3, 4, 6,0,32'h2002, 1,1, 6,0,32'h2002,0);
    vecs[2]  = mk(0,1,1, 10, 0, 7,1,32'h3003, 1,1, 7,1,32'h3003,0);
    vecs[3]  = mk(0,1,1,  7, 1, 8,0,32'h4004, 0,0, 7,1,32'h3003,1);
    vecs[4]  = mk(0,1,1,  7, 1, 8,0,32'h4004, 0,0, 7,1,32'h3003,2);
    vecs[5]  = mk(0,1,1,  7, 1, 8,0,32'h4004, 1,1, 8,0,32'h4004,2);
    vecs[6]  = mk(0,1,0,  2, 3, 9,0,32'h5005, 0,1, 8,0,32'h4004,2);
    vecs[7]  = mk(0,1,0,  2, 3, 9,0,32'h5005, 0,1, 8,0,32'h4004,2);
    vecs[8]  = mk(0,1,0,  2, 3, 9,0,32'h5005, 0,1, 8,0,32'h4004,2);
    vecs[9]  = mk(0,1,1,  2, 3, 9,0,32'h5005, 1,1, 9,0,32'h5005,2);
    vecs[10] = mk(0,1,1,  1, 0, 0,1,32'h6006, 1,1, 0,1,32'h6006,2);
    vecs[11] = mk(0,1,1,  0, 0, 3,0,32'h7007, 1,1, 3,0,32'h7007,2);
    vecs[12] = mk(0,1,1,  1, 0,12,1,32'h8008, 1,1,12,1,32'h8008,2);
    vecs[13] = mk(0,1,1,  0,12,13,0,32'h9009, 0,0,12,1,32'h8008,3);
    vecs[14] = mk(1,1,1,  0,12,13,0,32'h9009, 1,0,12,1,32'h8008,3);
    vecs[15] = mk(0,0,1,  0, 0, 0,0,32'h0,    1,0,12,1,32'h8008,3);
    vecs[16] = mk(0,1,1,  1, 0,14,0,32'hA00A, 1,1,14,0,32'hA00A,3);
    vecs[17] = mk(0,0,1,  0, 0, 0,0,32'h0,    1,0,14,0,32'hA00A,3);
    vecs[18] = mk(0,1,1,  1, 0,15,1,32'hB00B, 1,1,15,1,32'hB00B,3);
    vecs[19] = mk(0,1,0, 15, 0,16,0,32'hC00C, 0,1,15,1,32'hB00B,3);
    vecs[20] = mk(0,1,1, 15, 0,16,0,32'hC00C, 0,0,15,1,32'hB00B,4);
    vecs[21] = mk(0,1,1, 15, 0,16,0,32'hC00C, 0,0,15,1,32'hB00B,5);
    vecs[22] = mk(0,1,1, 15, 0,16,0,32'hC00C, 1,1,16,0,32'hC00C,5);
    vecs[23] = mk(1,1,1,  1, 1,17,0,32'hD00D, 1,0,16,0,32'hC00C,5);

    // Reset
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_out_valid", 128'(out_valid), 128'(1'b0));
    chk("reset_in_ready", 128'(in_ready), 128'(1'b1));
    chk("reset_stall_cnt", 128'(out_stall_cnt), 128'(16'd0));
    chk("reset_fields", {out_pc, out_rdata1, out_rdata2, out_imm},
        {32'd0, 32'd0, 32'd0, 32'd0});
    chk("reset_idx", {out_rs1, out_rs2, out_rd, out_ctrl, out_is_load}, 128'd0);

    // Table: inputs held for one cycle, in_ready checked before the edge
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      drive(vecs[i].fl, vecs[i].vl, vecs[i].rdy, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
            vecs[i].ld, vecs[i].d1);
      #1;
      chk($sformatf("v%0d_in_ready", i), 128'(in_ready), 128'(vecs[i].e_irdy));
      @(posedge clk);
      #1;
      d = vecs[i].e_d1;
      chk($sformatf("v%0d_out_valid", i), 128'(out_valid), 128'(vecs[i].e_ovld));
      chk($sformatf("v%0d_rd_ld_d1", i), {out_rd, out_is_load, out_rdata1},
          {vecs[i].e_rd, vecs[i].e_ld, vecs[i].e_d1});
      chk($sformatf("v%0d_side", i), {out_rdata2, out_pc, out_imm, out_ctrl},
          {d ^ 32'hFFFF_0000, d + 32'd4, ~d, d[7:0] ^ 8'h5A});
      chk($sformatf("v%0d_stall_cnt", i), 128'(out_stall_cnt), 128'(vecs[i].e_stall));
    end

    // Writeback bypass on accept (both operands name x9)
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 5'd9, 5'd9, 5'd1, 1'b0, 32'h11);
    in_rdata2 = 32'h22;
    wb_we = 1'b1; wb_rd = 5'd9; wb_data = 32'hABCD;
    @(posedge clk); #1;
    chk("fwd_accept_rs1", 128'(out_rdata1), 128'(FWD ? 32'hABCD : 32'h11));
    chk("fwd_accept_rs2", 128'(out_rdata2), 128'(FWD ? 32'hABCD : 32'h22));

    // Writeback bypass into a held instruction
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0; wb_data = 32'h1234;
    @(posedge clk); #1;
    chk("fwd_hold_valid", 128'(out_valid), 128'(1'b1));
    chk("fwd_hold_rs1", 128'(out_rdata1), 128'(FWD ? 32'h1234 : 32'h11));

    // Writeback to x0 is never forwarded
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 5'd0, 5'd2, 5'd3, 1'b0, 32'h33);
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'h5555;
    @(posedge clk); #1;
    chk("fwd_x0_rs1", 128'(out_rdata1), 128'(32'h33));

    // Writeback disabled: no bypass even on index match
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 5'd9, 5'd2, 5'd4, 1'b0, 32'h44);
    wb_we = 1'b0; wb_rd = 5'd9; wb_data = 32'h7777;
    @(posedge clk); #1;
    chk("fwd_we0_rs1", 128'(out_rdata1), 128'(32'h44));

    // Mid-run reset clears valid, payload and stall counter
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst2_out_valid", 128'(out_valid), 128'(1'b0));
    chk("rst2_stall_cnt", 128'(out_stall_cnt), 128'(16'd0));
    chk("rst2_rdata1", 128'(out_rdata1), 128'(32'd0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
